// File: rtl/seq_adder_nb.sv
// -----------------------------------------------------------------------------
// seq_adder_nb
// Multi-cycle add/subtract unit. Operands are captured on start and then
// consumed DIGIT bits per clock, LSB first, through a DIGIT-bit ripple slice.
// The result is assembled in a shift register and loaded into S, together with
// the signed-overflow flag, on the final RUN cycle. done pulses for one cycle
// when S/overflow become valid. Start is accepted in IDLE and in DONE, so
// back-to-back operations need no idle gap.
//
// Parameters:
//   WIDTH    operand width (>= 2)
//   DIGIT    bits processed per clock (must divide WIDTH)
//
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     operation request, sampled only while busy = 0
//   mode      0 = A+B, 1 = A-B (captured with start)
//   A, B      operands (captured with start)
//   busy      high while the unit is iterating
//   done      one-cycle pulse, S/overflow valid from this cycle on
//   S         {carry-out, sum}; in subtract mode carry-out = 1 means no borrow
//   overflow  two's-complement overflow of S[WIDTH-1:0]
// -----------------------------------------------------------------------------
module seq_adder_nb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   S,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // B already conditioned for subtract
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic [DIGIT-1:0] sum_digit;
    logic             carry_next;
    logic             cin_msb;    // carry entering the top bit of this slice
    logic [WIDTH-1:0] res_next;
    logic             last_digit;

    // Ripple slice over the low DIGIT bits of the operand shift registers.
    // cin_msb is only meaningful on the last digit, where the slice's top bit
    // is the operand MSB.
    always_comb begin
        sum_digit  = '0;
        carry_next = carry_reg;
        cin_msb    = carry_reg;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                cin_msb = carry_next;
            end
            sum_digit[i] = a_reg[i] ^ b_reg[i] ^ carry_next;
            carry_next   = (a_reg[i] & b_reg[i]) | (carry_next & (a_reg[i] ^ b_reg[i]));
        end
    end

    // New digit enters from the MSB side, so after N digits the result
    // register holds the sum in natural bit order.
    assign res_next   = (res_reg >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));
    assign last_digit = (cnt_reg == CW'(N - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            S         <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B, seed carry with 1.
                        a_reg     <= A;
                        b_reg     <= B ^ {WIDTH{mode}};
                        carry_reg <= mode;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        S         <= {carry_next, res_next};
                        overflow  <= carry_next ^ cin_msb;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder_nb.sv
// -----------------------------------------------------------------------------
// tb_seq_adder_nb
// Bench for seq_adder_nb. Three instances: WIDTH=8/DIGIT=1, WIDTH=16/DIGIT=4
// and WIDTH=16/DIGIT=16. Expected sums, borrows and overflow flags come from
// plain integer arithmetic and sign rules; latency expectations come from
// WIDTH/DIGIT. Each operation prints one line.
// -----------------------------------------------------------------------------
module tb_seq_adder_nb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic        start0, mode0;
    logic [7:0]  a0, b0;
    logic        busy0, done0, ov0;
    logic [8:0]  s0;

    logic        start1, mode1;
    logic [15:0] a1, b1;
    logic        busy1, done1, ov1;
    logic [16:0] s1;

    logic        start2, mode2;
    logic [15:0] a2, b2;
    logic        busy2, done2, ov2;
    logic [16:0] s2;

    seq_adder_nb #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .mode(mode0),
        .A(a0), .B(b0), .busy(busy0), .done(done0), .S(s0), .overflow(ov0)
    );

    seq_adder_nb #(.WIDTH(16), .DIGIT(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .mode(mode1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .S(s1), .overflow(ov1)
    );

    seq_adder_nb #(.WIDTH(16), .DIGIT(16)) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .mode(mode2),
        .A(a2), .B(b2), .busy(busy2), .done(done2), .S(s2), .overflow(ov2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] last_s [3];
    int w_of [3] = '{8, 16, 16};
    int n_of [3] = '{8, 4, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact sum, or (A-B) mod 2^w with "no borrow" in bit w.
    function automatic logic [16:0] ref_s(input int w, input bit m,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (!m) begin
            r = {1'b0, a} + {1'b0, b};
        end else begin
            r = {1'b0, (a - b) & mask};
            r[w] = (a >= b);
        end
        return r;
    endfunction

    // Signed overflow: add of like signs, or subtract of unlike signs,
    // giving a result whose sign differs from A.
    function automatic bit ref_ov(input int w, input bit m, input logic [15:0] a,
                                  input logic [15:0] b, input logic [16:0] r);
        bit sa, sb, sr;
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        if (m) return (sa != sb) && (sr != sa);
        return (sa == sb) && (sr != sa);
    endfunction

    task automatic drive(input int sel, input bit s, input bit m,
                         input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0: begin start0 = s; mode0 = m; a0 = a[7:0]; b0 = b[7:0]; end
            1: begin start1 = s; mode1 = m; a1 = a; b1 = b; end
            default: begin start2 = s; mode2 = m; a2 = a; b2 = b; end
        endcase
    endtask

    function automatic bit get_done(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic bit get_busy(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic bit get_ov(input int sel);
        case (sel)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [16:0] get_s(input int sel);
        case (sel)
            0: return {8'b0, s0};
            1: return s1;
            default: return s2;
        endcase
    endfunction

    // Asserts start at the current sample point and waits for done. Returns
    // at the sample point where done is high. glitch_at (if >0) pulses start
    // with junk operands at that RUN cycle to show it is ignored.
    task automatic start_and_wait(input int sel, input bit m, input logic [15:0] a_in,
                                  input logic [15:0] b_in, input int glitch_at,
                                  input string tag);
        int lat;
        int busy_cnt;
        int w;
        int n;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] es;
        bit eo;
        w = w_of[sel];
        n = n_of[sel];
        a = (w == 16) ? a_in : {8'h00, a_in[7:0]};
        b = (w == 16) ? b_in : {8'h00, b_in[7:0]};
        es = ref_s(w, m, a, b);
        eo = ref_ov(w, m, a, b, es);
        busy_cnt = 0;
        drive(sel, 1'b1, m, a, b);
        @(posedge clock); #1;
        lat = 1;
        drive(sel, 1'b0, m, a, b);
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) busy_cnt++;
            if (lat == 2) check({tag, "_hold"}, 32'(get_s(sel)), 32'(last_s[sel]));
            if (lat == glitch_at) drive(sel, 1'b1, ~m, 16'($urandom), 16'($urandom));
            else drive(sel, 1'b0, m, a, b);
            @(posedge clock); #1;
            lat++;
        end
        drive(sel, 1'b0, m, a, b);
        check({tag, "_done"}, 32'(get_done(sel)), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(n + 1));
        check({tag, "_busycyc"}, 32'(busy_cnt), 32'(n));
        check({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd0);
        check({tag, "_S"}, 32'(get_s(sel)), 32'(es));
        check({tag, "_ov"}, 32'(get_ov(sel)), 32'(eo));
        last_s[sel] = es;
        $display("op %s dut=%0d mode=%0d a=%h b=%h S=%h ov=%0d lat=%0d",
                 tag, sel, m, a, b, get_s(sel), get_ov(sel), lat);
    endtask

    // Full operation followed by one idle cycle: done must drop, S must hold.
    task automatic op(input int sel, input bit m, input logic [15:0] a,
                      input logic [15:0] b, input int glitch_at, input string tag);
        start_and_wait(sel, m, a, b, glitch_at, tag);
        @(posedge clock); #1;
        check({tag, "_pulse"}, 32'(get_done(sel)), 32'd0);
        check({tag, "_idle_hold"}, 32'(get_s(sel)), 32'(last_s[sel]));
    endtask

    initial begin
        int seen_done;
        int seen_busy;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(2, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) last_s[i] = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(get_busy(i)), 32'd0);
            check("rst_done", 32'(get_done(i)), 32'd0);
            check("rst_S", 32'(get_s(i)), 32'd0);
            check("rst_ov", 32'(get_ov(i)), 32'd0);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed cases, WIDTH=8 DIGIT=1
        op(0, 1'b0, 16'd200, 16'd100, 0, "add_200_100");
        check("S_12C", 32'(s0), 32'h12C);
        op(0, 1'b0, 16'd127, 16'd1,   0, "add_127_1");
        check("S_080", 32'(s0), 32'h080);
        op(0, 1'b0, 16'd128, 16'd128, 0, "add_128_128");
        check("S_100", 32'(s0), 32'h100);
        op(0, 1'b1, 16'd7,   16'd5,   0, "sub_7_5");
        check("S_102", 32'(s0), 32'h102);
        op(0, 1'b1, 16'd5,   16'd7,   0, "sub_5_7");
        check("S_0FE", 32'(s0), 32'h0FE);
        op(0, 1'b1, 16'd128, 16'd1,   0, "sub_128_1");
        check("S_17F", 32'(s0), 32'h17F);
        check("ov_17F", 32'(ov0), 32'd1);
        op(0, 1'b0, 16'hFF,  16'hFF,  0, "add_ff_ff");
        op(0, 1'b1, 16'h00,  16'hFF,  0, "sub_00_ff");
        op(0, 1'b1, 16'h55,  16'h55,  0, "sub_equal");

        // start pulsed during RUN cycle 3 must not disturb the result
        op(0, 1'b0, 16'd200, 16'd100, 3, "glitch");

        // back-to-back: start held in the DONE cycle
        start_and_wait(0, 1'b0, 16'd10, 16'd20, 0, "b2b_first");
        op(0, 1'b1, 16'd3, 16'd9, 0, "b2b_second");

        // reset during RUN cycle 4
        drive(0, 1'b1, 1'b0, 16'd200, 16'd100);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            drive(0, 1'b0, 1'b0, 16'd200, 16'd100);
        end
        check("mid_busy_before", 32'(busy0), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        check("mid_rst_S", 32'(s0), 32'd0);
        check("mid_rst_ov", 32'(ov0), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) last_s[i] = '0;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done0) seen_done++;
            if (busy0) seen_busy++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);
        check("mid_rst_no_busy", 32'(seen_busy), 32'd0);
        $display("op reset_mid_run dut=0 done_after=%0d", seen_done);
        op(0, 1'b0, 16'd1, 16'd2, 0, "after_rst");

        // Wider instances
        op(1, 1'b0, 16'hFFFF, 16'h0001, 0, "w16d4_ffff_1");
        check("S_10000_d4", 32'(s1), 32'h10000);
        op(2, 1'b0, 16'hFFFF, 16'h0001, 0, "w16d16_ffff_1");
        check("S_10000_d16", 32'(s2), 32'h10000);
        op(1, 1'b1, 16'h8000, 16'h0001, 0, "w16d4_sub_ov");
        op(1, 1'b0, 16'h7FFF, 16'h0001, 2, "w16d4_add_ov");
        start_and_wait(1, 1'b0, 16'h1234, 16'h4321, 0, "w16d4_b2b1");
        op(1, 1'b1, 16'h0001, 16'h1234, 0, "w16d4_b2b2");
        start_and_wait(2, 1'b1, 16'h0000, 16'h0001, 0, "w16d16_b2b1");
        op(2, 1'b0, 16'h8000, 16'h8000, 0, "w16d16_b2b2");

        // Randomized
        for (int i = 0; i < 30; i++)
            op(0, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 7)), "rnd8");
        for (int i = 0; i < 20; i++)
            op(1, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rnd16d4");
        for (int i = 0; i < 15; i++)
            op(2, 1'($urandom), 16'($urandom), 16'($urandom), 0, "rnd16d16");
        for (int i = 0; i < 6; i++)
            start_and_wait(0, 1'($urandom), 16'($urandom), 16'($urandom), 0, "rnd8_b2b");
        op(0, 1'($urandom), 16'($urandom), 16'($urandom), 0, "rnd8_b2b_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
